mem_read_arbiter: RTL and testbench
===================================

Name: mem_read_arbiter

Overview:
Shares one downstream memory read port between the instruction-cache refill path and the data-cache miss-read path of top_tile. It sits between the core tile and the L2/memory model.
- Requests are forwarded with a source tag in the ID.
- Responses are routed back by that tag.
- The icache request, which has no ready, is held in a one-entry buffer.
- The number of dcache reads in flight is limited.

Parameters:
ADDR_W, 40, memory request address width
IC_ADDR_W, 26, icache line-address width
OFFSET_W, 6, line-offset bits appended to the icache address
LINE_W, 256, response data width
ID_W, 4, dcache request ID width
MAX_DC_OUT, 4, maximum outstanding dcache reads (power of 2 not required)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
ic_valid_i  in  1  icache refill request, single-cycle pulse
ic_addr_i  in  IC_ADDR_W  icache line address
ic_valid_o  out  1  icache response valid, single-cycle pulse
ic_line_o  out  LINE_W  icache response line
ic_busy_o  out  1  icache transaction buffered or outstanding
ic_overflow_o  out  1  pulse: icache request dropped
dc_req_valid_i  in  1  dcache miss-read request valid
dc_req_ready_o  out  1  dcache request accepted
dc_req_addr_i  in  ADDR_W  dcache request address
dc_req_id_i  in  ID_W  dcache request ID
dc_resp_valid_o  out  1  dcache response beat valid
dc_resp_ready_i  in  1  dcache ready for response beat
dc_resp_data_o  out  LINE_W  dcache response data
dc_resp_id_o  out  ID_W  dcache response ID
dc_resp_last_o  out  1  last beat of dcache response
mem_req_valid_o  out  1  downstream request valid
mem_req_ready_i  in  1  downstream request ready
mem_req_addr_o  out  ADDR_W  downstream address
mem_req_id_o  out  ID_W+1  {source bit (1 = IC), id}
mem_resp_valid_i  in  1  downstream response beat valid
mem_resp_ready_o  out  1  downstream response ready
mem_resp_data_i  in  LINE_W  downstream response data
mem_resp_id_i  in  ID_W+1  downstream response ID
mem_resp_last_i  in  1  last beat of downstream response
spurious_resp_o  out  1  pulse: response with no matching outstanding transaction

Behaviour:
- Reset clears the icache buffer, icache outstanding flag, dcache outstanding counter, round-robin pointer (pointing at IC first) and perf counters. All outputs read 0 in the first cycle after reset.
- Reset mid-operation abandons in-flight transactions. Any later response then counts as spurious.
- **Icache capture**
  - When ic_valid_i arrives and the icache is idle (no buffer entry, nothing outstanding), the request is latched next cycle.
  - Latched address: mem address = zero-extended {ic_addr_i, OFFSET_W'b0}, truncated to ADDR_W.
  - When ic_valid_i arrives while the icache is busy, the request is dropped and ic_overflow_o pulses next cycle.
- ic_busy_o = buffer valid | icache outstanding.
- **Arbitration**
  - Candidates: IC = buffer valid; DC = dc_req_valid_i AND dc outstanding count < MAX_DC_OUT.
  - Round-robin between candidates; the pointer moves to the other source after each handshake.
  - A single candidate is granted without waiting.
- mem_req_valid_o and mem_req_addr_o/mem_req_id_o remain stable from assertion until mem_req_ready_i. Once asserted, the grant is not re-arbitrated.
- dc_req_ready_o = DC granted AND mem_req_ready_i, combinational.
- An IC handshake clears the buffer and sets the icache outstanding flag. A DC handshake increments the dcache counter.
- mem_req_id_o: IC requests send {1, 0}; DC requests send {0, dc_req_id_i}.
- **Response routing** (combinational, zero latency)
  - Source bit 1:
    - mem_resp_ready_o = 1.
    - ic_valid_o = mem_resp_valid_i AND mem_resp_last_i AND icache outstanding.
    - Handshake on last beat clears the outstanding flag.
    - Icache responses are single-beat; non-last IC beats are consumed and discarded.
  - Source bit 0:
    - mem_resp_ready_o = dc_resp_ready_i.
    - Data, id and last pass through.
    - The counter decrements on a handshake with last.
- Simultaneous DC request handshake and DC last-beat response: the counter is unchanged.
- A response for a source with nothing outstanding is consumed (ready = 1) and not forwarded; spurious_resp_o pulses in the same cycle.
- The dcache counter saturates at 0 and never exceeds MAX_DC_OUT.

Optional Feature:
- Macro: MEM_ARB_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_ic_grants_o, perf_dc_grants_o and perf_stall_cycles_o, each 32 bits, wrapping at 2^32, reset to 0.
  - perf_stall_cycles_o counts cycles with mem_req_valid_o=1 and mem_req_ready_i=0.
- Undefined: these ports and counters are absent and all other behaviour is identical.

Decomposition:
- Package mem_arb_pkg holds:
  - source enum {SRC_DC=0, SRC_IC=1};
  - the mem request struct {addr, id};
  - the mem response struct {data, id, last};
  - the parameter defaults.
- One sub-module, mem_arb_rr: a two-input round-robin grant with a hold-until-ready lock.

Test Plan:
- **IC alone:** ic_valid_i with addr 0x000004 → mem_req_addr_o=0x100, id=0x10. Respond with one last beat of 0xA5.. → ic_valid_o pulses once with the line; ic_busy_o falls.
- **Contention:** IC buffered and dc_req_valid_i held with ids 1..3 → grants alternate IC, DC1, then DC2, DC3 once IC is idle.
- **Outstanding limit:** 4 DC requests accepted without responses → 5th request sees dc_req_ready_o=0 until a last beat returns, then it is accepted.
- **Backpressure:** mem_req_ready_i=0 for 5 cycles → addr/id remain stable. With MEM_ARB_PERF_CNT_EN defined, perf_stall_cycles_o = 5.
- **IC overflow and spurious response:** second ic_valid_i while busy → ic_overflow_o pulses and no second request is issued. IC response with no IC outstanding → spurious_resp_o pulses.
- **Reset:** rst_i asserted with 2 DC outstanding → counter=0 and no grants. Late response → consumed and spurious_resp_o pulses.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and parameter defaults for the memory read arbiter.
// The request/response structs are sized from the default widths below.
package mem_arb_pkg;

    localparam int ADDR_W_DEF     = 40;
    localparam int IC_ADDR_W_DEF  = 26;
    localparam int OFFSET_W_DEF   = 6;
    localparam int LINE_W_DEF     = 256;
    localparam int ID_W_DEF       = 4;
    localparam int MAX_DC_OUT_DEF = 4;

    typedef enum logic {
        SRC_DC = 1'b0,
        SRC_IC = 1'b1
    } src_e;

    typedef struct packed {
        logic [ADDR_W_DEF-1:0] addr;
        logic [ID_W_DEF:0]     id;
    } mem_req_t;

    typedef struct packed {
        logic [LINE_W_DEF-1:0] data;
        logic [ID_W_DEF:0]     id;
        logic                  last;
    } mem_resp_t;

endpackage

// File: rtl/mem_arb_rr.sv
// Two-input round-robin grant. Once a grant is presented it is locked
// until the downstream ready completes the handshake.
module mem_arb_rr
    import mem_arb_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic ic_req,
    input  logic dc_req,
    input  logic ready,
    output logic valid,
    output logic grant_ic,
    output logic grant_dc
);

    logic lock_r;
    src_e lock_src_r;
    src_e ptr_r;
    logic valid_s;
    src_e sel_s;

    // Pick a source: a locked grant wins, otherwise the pointer breaks ties.
    always_comb begin
        valid_s = 1'b0;
        sel_s   = SRC_DC;
        if (lock_r) begin
            valid_s = 1'b1;
            sel_s   = lock_src_r;
        end else if (ic_req && dc_req) begin
            valid_s = 1'b1;
            sel_s   = ptr_r;
        end else if (ic_req) begin
            valid_s = 1'b1;
            sel_s   = SRC_IC;
        end else if (dc_req) begin
            valid_s = 1'b1;
            sel_s   = SRC_DC;
        end else begin
            valid_s = 1'b0;
            sel_s   = SRC_DC;
        end
    end

    // Lock a stalled grant; after a handshake favour the other source.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lock_r     <= 1'b0;
            lock_src_r <= SRC_DC;
            ptr_r      <= SRC_IC;
        end else if (valid_s && ready) begin
            lock_r <= 1'b0;
            case (sel_s)
                SRC_IC:  ptr_r <= SRC_DC;
                SRC_DC:  ptr_r <= SRC_IC;
                default: ptr_r <= SRC_IC;
            endcase
        end else if (valid_s) begin
            lock_r     <= 1'b1;
            lock_src_r <= sel_s;
        end else begin
            lock_r <= 1'b0;
        end
    end

    assign valid    = valid_s;
    assign grant_ic = valid_s && (sel_s == SRC_IC);
    assign grant_dc = valid_s && (sel_s == SRC_DC);

endmodule

// File: rtl/mem_read_arbiter.sv
// Shares one memory read port between icache refills and dcache miss reads.
// Define MEM_ARB_PERF_CNT_EN to add grant and stall performance counters.
module mem_read_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int IC_ADDR_W  = IC_ADDR_W_DEF,
    parameter int OFFSET_W   = OFFSET_W_DEF,
    parameter int LINE_W     = LINE_W_DEF,
    parameter int ID_W       = ID_W_DEF,
    parameter int MAX_DC_OUT = MAX_DC_OUT_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              ic_valid_i,
    input  logic [IC_ADDR_W-1:0] ic_addr_i,
    output logic              ic_valid_o,
    output logic [LINE_W-1:0] ic_line_o,
    output logic              ic_busy_o,
    output logic              ic_overflow_o,
    input  logic              dc_req_valid_i,
    output logic              dc_req_ready_o,
    input  logic [ADDR_W-1:0] dc_req_addr_i,
    input  logic [ID_W-1:0]   dc_req_id_i,
    output logic              dc_resp_valid_o,
    input  logic              dc_resp_ready_i,
    output logic [LINE_W-1:0] dc_resp_data_o,
    output logic [ID_W-1:0]   dc_resp_id_o,
    output logic              dc_resp_last_o,
    output logic              mem_req_valid_o,
    input  logic              mem_req_ready_i,
    output logic [ADDR_W-1:0] mem_req_addr_o,
    output logic [ID_W:0]     mem_req_id_o,
    input  logic              mem_resp_valid_i,
    output logic              mem_resp_ready_o,
    input  logic [LINE_W-1:0] mem_resp_data_i,
    input  logic [ID_W:0]     mem_resp_id_i,
    input  logic              mem_resp_last_i,
    output logic              spurious_resp_o
`ifdef MEM_ARB_PERF_CNT_EN
    ,
    output logic [31:0]       perf_ic_grants_o,
    output logic [31:0]       perf_dc_grants_o,
    output logic [31:0]       perf_stall_cycles_o
`endif
);

    localparam int CNT_W = $clog2(MAX_DC_OUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_DC_OUT);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic                 buf_valid_r;
    logic [ADDR_W-1:0]    buf_addr_r;
    logic                 ic_out_r;
    logic                 ic_ovf_r;
    logic [CNT_W-1:0]     dc_cnt_r;

    logic                 ic_busy_s;
    logic [ADDR_W+IC_ADDR_W+OFFSET_W-1:0] ic_wide_s;
    logic                 dc_cand_s;
    logic                 arb_valid_s;
    logic                 gnt_ic_s;
    logic                 gnt_dc_s;
    logic                 dc_inc_s;
    logic                 dc_dec_s;
    mem_req_t             req_s;
    mem_resp_t            resp_s;
    src_e                 resp_src_s;
    logic                 resp_ready_s;
    logic                 ic_hit_s;
    logic                 dc_fwd_s;
    logic                 spurious_s;

    assign ic_busy_s = buf_valid_r || ic_out_r;
    // Wide zero-extension lets the line address be truncated or padded to ADDR_W.
    assign ic_wide_s = {{ADDR_W{1'b0}}, ic_addr_i, {OFFSET_W{1'b0}}};
    assign dc_cand_s = dc_req_valid_i && (dc_cnt_r < CNT_MAX);

    mem_arb_rr u_rr (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .ic_req   (buf_valid_r),
        .dc_req   (dc_cand_s),
        .ready    (mem_req_ready_i),
        .valid    (arb_valid_s),
        .grant_ic (gnt_ic_s),
        .grant_dc (gnt_dc_s)
    );

    // Build the downstream request from the granted source.
    always_comb begin
        req_s = '0;
        if (gnt_ic_s) begin
            req_s.addr = buf_addr_r;
            req_s.id   = {1'b1, {ID_W{1'b0}}};
        end else if (gnt_dc_s) begin
            req_s.addr = dc_req_addr_i;
            req_s.id   = {1'b0, dc_req_id_i};
        end else begin
            req_s = '0;
        end
    end

    // Route responses by source bit; unmatched responses are swallowed.
    always_comb begin
        resp_s.data  = mem_resp_data_i;
        resp_s.id    = mem_resp_id_i;
        resp_s.last  = mem_resp_last_i;
        resp_src_s   = src_e'(resp_s.id[ID_W]);
        resp_ready_s = 1'b0;
        ic_hit_s     = 1'b0;
        dc_fwd_s     = 1'b0;
        spurious_s   = 1'b0;
        case (resp_src_s)
            SRC_IC: begin
                resp_ready_s = 1'b1;
                if (ic_out_r) begin
                    ic_hit_s = mem_resp_valid_i && resp_s.last;
                end else begin
                    spurious_s = mem_resp_valid_i;
                end
            end
            SRC_DC: begin
                if (dc_cnt_r != CNT_ZERO) begin
                    dc_fwd_s     = mem_resp_valid_i;
                    resp_ready_s = dc_resp_ready_i;
                end else begin
                    resp_ready_s = mem_resp_valid_i;
                    spurious_s   = mem_resp_valid_i;
                end
            end
            default: begin
                resp_ready_s = 1'b0;
            end
        endcase
    end

    assign dc_inc_s = gnt_dc_s && mem_req_ready_i;
    assign dc_dec_s = dc_fwd_s && dc_resp_ready_i && resp_s.last;

    // Icache buffer / outstanding flag and dcache in-flight counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            buf_valid_r <= 1'b0;
            buf_addr_r  <= {ADDR_W{1'b0}};
            ic_out_r    <= 1'b0;
            ic_ovf_r    <= 1'b0;
            dc_cnt_r    <= CNT_ZERO;
        end else begin
            ic_ovf_r <= ic_valid_i && ic_busy_s;
            if (ic_valid_i && !ic_busy_s) begin
                buf_valid_r <= 1'b1;
                buf_addr_r  <= ic_wide_s[ADDR_W-1:0];
            end else if (gnt_ic_s && mem_req_ready_i) begin
                buf_valid_r <= 1'b0;
            end
            if (gnt_ic_s && mem_req_ready_i) begin
                ic_out_r <= 1'b1;
            end else if (ic_hit_s) begin
                ic_out_r <= 1'b0;
            end
            if (dc_inc_s && !dc_dec_s && (dc_cnt_r < CNT_MAX)) begin
                dc_cnt_r <= dc_cnt_r + CNT_ONE;
            end else if (dc_dec_s && !dc_inc_s && (dc_cnt_r != CNT_ZERO)) begin
                dc_cnt_r <= dc_cnt_r - CNT_ONE;
            end
        end
    end

`ifdef MEM_ARB_PERF_CNT_EN
    logic [31:0] perf_ic_r;
    logic [31:0] perf_dc_r;
    logic [31:0] perf_stall_r;

    // Free-running grant and stall counters, wrapping at 2^32.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perf_ic_r    <= 32'd0;
            perf_dc_r    <= 32'd0;
            perf_stall_r <= 32'd0;
        end else begin
            if (gnt_ic_s && mem_req_ready_i) perf_ic_r <= perf_ic_r + 32'd1;
            if (dc_inc_s) perf_dc_r <= perf_dc_r + 32'd1;
            if (arb_valid_s && !mem_req_ready_i) perf_stall_r <= perf_stall_r + 32'd1;
        end
    end

    assign perf_ic_grants_o    = perf_ic_r;
    assign perf_dc_grants_o    = perf_dc_r;
    assign perf_stall_cycles_o = perf_stall_r;
`endif

    assign ic_busy_o       = ic_busy_s;
    assign ic_overflow_o   = ic_ovf_r;
    assign ic_valid_o      = ic_hit_s;
    assign ic_line_o       = ic_hit_s ? resp_s.data : {LINE_W{1'b0}};
    assign dc_req_ready_o  = gnt_dc_s && mem_req_ready_i;
    assign dc_resp_valid_o = dc_fwd_s;
    assign dc_resp_data_o  = dc_fwd_s ? resp_s.data : {LINE_W{1'b0}};
    assign dc_resp_id_o    = dc_fwd_s ? resp_s.id[ID_W-1:0] : {ID_W{1'b0}};
    assign dc_resp_last_o  = dc_fwd_s && resp_s.last;
    assign mem_req_valid_o = arb_valid_s;
    assign mem_req_addr_o  = req_s.addr;
    assign mem_req_id_o    = req_s.id;
    assign mem_resp_ready_o = resp_ready_s;
    assign spurious_resp_o = spurious_s;

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Directed self-checking bench for mem_read_arbiter (perf checks when
// MEM_ARB_PERF_CNT_EN is defined).
module tb_mem_read_arbiter;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         ic_valid_i;
    logic [25:0]  ic_addr_i;
    logic         ic_valid_o;
    logic [255:0] ic_line_o;
    logic         ic_busy_o;
    logic         ic_overflow_o;
    logic         dc_req_valid_i;
    logic         dc_req_ready_o;
    logic [39:0]  dc_req_addr_i;
    logic [3:0]   dc_req_id_i;
    logic         dc_resp_valid_o;
    logic         dc_resp_ready_i;
    logic [255:0] dc_resp_data_o;
    logic [3:0]   dc_resp_id_o;
    logic         dc_resp_last_o;
    logic         mem_req_valid_o;
    logic         mem_req_ready_i;
    logic [39:0]  mem_req_addr_o;
    logic [4:0]   mem_req_id_o;
    logic         mem_resp_valid_i;
    logic         mem_resp_ready_o;
    logic [255:0] mem_resp_data_i;
    logic [4:0]   mem_resp_id_i;
    logic         mem_resp_last_i;
    logic         spurious_resp_o;
`ifdef MEM_ARB_PERF_CNT_EN
    logic [31:0]  perf_ic_grants_o;
    logic [31:0]  perf_dc_grants_o;
    logic [31:0]  perf_stall_cycles_o;
`endif

    int errors = 0;
    int checks = 0;
    logic [255:0] line_a5;

    mem_read_arbiter dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .ic_valid_i       (ic_valid_i),
        .ic_addr_i        (ic_addr_i),
        .ic_valid_o       (ic_valid_o),
        .ic_line_o        (ic_line_o),
        .ic_busy_o        (ic_busy_o),
        .ic_overflow_o    (ic_overflow_o),
        .dc_req_valid_i   (dc_req_valid_i),
        .dc_req_ready_o   (dc_req_ready_o),
        .dc_req_addr_i    (dc_req_addr_i),
        .dc_req_id_i      (dc_req_id_i),
        .dc_resp_valid_o  (dc_resp_valid_o),
        .dc_resp_ready_i  (dc_resp_ready_i),
        .dc_resp_data_o   (dc_resp_data_o),
        .dc_resp_id_o     (dc_resp_id_o),
        .dc_resp_last_o   (dc_resp_last_o),
        .mem_req_valid_o  (mem_req_valid_o),
        .mem_req_ready_i  (mem_req_ready_i),
        .mem_req_addr_o   (mem_req_addr_o),
        .mem_req_id_o     (mem_req_id_o),
        .mem_resp_valid_i (mem_resp_valid_i),
        .mem_resp_ready_o (mem_resp_ready_o),
        .mem_resp_data_i  (mem_resp_data_i),
        .mem_resp_id_i    (mem_resp_id_i),
        .mem_resp_last_i  (mem_resp_last_i),
        .spurious_resp_o  (spurious_resp_o)
`ifdef MEM_ARB_PERF_CNT_EN
        ,
        .perf_ic_grants_o    (perf_ic_grants_o),
        .perf_dc_grants_o    (perf_dc_grants_o),
        .perf_stall_cycles_o (perf_stall_cycles_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        line_a5          = {8{32'hA5A5_A5A5}};
        rst_i            = 1'b1;
        ic_valid_i       = 1'b0;
        ic_addr_i        = 26'h0;
        dc_req_valid_i   = 1'b0;
        dc_req_addr_i    = 40'h0;
        dc_req_id_i      = 4'h0;
        dc_resp_ready_i  = 1'b0;
        mem_req_ready_i  = 1'b0;
        mem_resp_valid_i = 1'b0;
        mem_resp_data_i  = 256'h0;
        mem_resp_id_i    = 5'h0;
        mem_resp_last_i  = 1'b0;
        repeat (3) tick;
        rst_i = 1'b0;
        #1;
        check("rst_req_valid", mem_req_valid_o, 1'b0);
        check("rst_req_addr", mem_req_addr_o, 40'h0);
        check("rst_dc_ready", dc_req_ready_o, 1'b0);
        check("rst_ic_busy", ic_busy_o, 1'b0);
        check("rst_ic_valid", ic_valid_o, 1'b0);
        check("rst_ic_ovf", ic_overflow_o, 1'b0);
        check("rst_dc_resp_valid", dc_resp_valid_o, 1'b0);
        check("rst_resp_ready", mem_resp_ready_o, 1'b0);
        check("rst_spurious", spurious_resp_o, 1'b0);

        // IC alone
        tick;
        ic_valid_i = 1'b1;
        ic_addr_i  = 26'h000004;
        #1;
        check("ic_not_yet", mem_req_valid_o, 1'b0);
        tick;
        ic_valid_i = 1'b0;
        #1;
        check("ic_busy_buf", ic_busy_o, 1'b1);
        check("ic_req_valid", mem_req_valid_o, 1'b1);
        check("ic_req_addr", mem_req_addr_o, 40'h100);
        check("ic_req_id", mem_req_id_o, 5'h10);
        check("ic_dc_ready", dc_req_ready_o, 1'b0);
        mem_req_ready_i = 1'b1;
        tick;
        mem_req_ready_i = 1'b0;
        #1;
        check("ic_sent_valid", mem_req_valid_o, 1'b0);
        check("ic_busy_out", ic_busy_o, 1'b1);
        mem_resp_valid_i = 1'b1;
        mem_resp_id_i    = 5'h10;
        mem_resp_last_i  = 1'b1;
        mem_resp_data_i  = line_a5;
        #1;
        check("ic_resp_valid", ic_valid_o, 1'b1);
        check("ic_resp_line", ic_line_o, line_a5);
        check("ic_resp_ready", mem_resp_ready_o, 1'b1);
        check("ic_resp_spur", spurious_resp_o, 1'b0);
        check("ic_resp_dc", dc_resp_valid_o, 1'b0);
        tick;
        mem_resp_valid_i = 1'b0;
        #1;
        check("ic_valid_pulse", ic_valid_o, 1'b0);
        check("ic_busy_clear", ic_busy_o, 1'b0);

        // Backpressure on a DC request
        dc_req_valid_i = 1'b1;
        dc_req_addr_i  = 40'h12_3456_789A;
        dc_req_id_i    = 4'h5;
        #1;
        check("bp_valid", mem_req_valid_o, 1'b1);
        check("bp_ready0", dc_req_ready_o, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick;
            check("bp_addr_stable", mem_req_addr_o, 40'h12_3456_789A);
            check("bp_id_stable", mem_req_id_o, 5'h05);
            check("bp_no_ready", dc_req_ready_o, 1'b0);
        end
`ifdef MEM_ARB_PERF_CNT_EN
        check("perf_stall5", perf_stall_cycles_o, 32'd5);
`endif
        mem_req_ready_i = 1'b1;
        #1;
        check("bp_accept", dc_req_ready_o, 1'b1);
        tick;
        dc_req_valid_i = 1'b0;
        #1;
        check("bp_done", mem_req_valid_o, 1'b0);
`ifdef MEM_ARB_PERF_CNT_EN
        check("perf_ic1", perf_ic_grants_o, 32'd1);
        check("perf_dc1", perf_dc_grants_o, 32'd1);
`endif

        // Outstanding limit: one in flight, three more fill it
        dc_req_valid_i = 1'b1;
        dc_req_id_i    = 4'h6;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("lim_accept", dc_req_ready_o, 1'b1);
            tick;
        end
        #1;
        check("lim_full_ready", dc_req_ready_o, 1'b0);
        check("lim_full_valid", mem_req_valid_o, 1'b0);
        tick;
        check("lim_still_full", dc_req_ready_o, 1'b0);
        mem_resp_valid_i = 1'b1;
        mem_resp_id_i    = 5'h05;
        mem_resp_last_i  = 1'b0;
        mem_resp_data_i  = 256'h77;
        dc_resp_ready_i  = 1'b1;
        #1;
        check("dc_beat_valid", dc_resp_valid_o, 1'b1);
        check("dc_beat_last", dc_resp_last_o, 1'b0);
        check("dc_beat_id", dc_resp_id_o, 4'h5);
        check("dc_beat_data", dc_resp_data_o, 256'h77);
        check("dc_beat_full", dc_req_ready_o, 1'b0);
        tick;
        mem_resp_last_i = 1'b1;
        #1;
        check("dc_last_flag", dc_resp_last_o, 1'b1);
        check("dc_last_full", dc_req_ready_o, 1'b0);
        tick;
        #1;
        check("lim_freed", dc_req_ready_o, 1'b1);
        tick;
        mem_resp_valid_i = 1'b0;
        #1;
        check("simul_unchanged", dc_req_ready_o, 1'b1);
        tick;
        #1;
        check("lim_full_again", dc_req_ready_o, 1'b0);
        mem_resp_valid_i = 1'b1;
        dc_resp_ready_i  = 1'b0;
        #1;
        check("dc_bp_ready", mem_resp_ready_o, 1'b0);
        check("dc_bp_valid", dc_resp_valid_o, 1'b1);
        mem_resp_valid_i = 1'b0;
        dc_resp_ready_i  = 1'b1;
        dc_req_valid_i   = 1'b0;

        // Reset with dcache reads in flight
        tick;
        rst_i = 1'b1;
        tick;
        rst_i = 1'b0;
        #1;
        check("mrst_valid", mem_req_valid_o, 1'b0);
        check("mrst_busy", ic_busy_o, 1'b0);
        mem_resp_valid_i = 1'b1;
        mem_resp_id_i    = 5'h05;
        mem_resp_last_i  = 1'b1;
        #1;
        check("late_spurious", spurious_resp_o, 1'b1);
        check("late_ready", mem_resp_ready_o, 1'b1);
        check("late_not_fwd", dc_resp_valid_o, 1'b0);
        tick;
        mem_resp_valid_i = 1'b0;
        #1;
        check("late_pulse", spurious_resp_o, 1'b0);
`ifdef MEM_ARB_PERF_CNT_EN
        check("perf_rst_ic", perf_ic_grants_o, 32'd0);
        check("perf_rst_stall", perf_stall_cycles_o, 32'd0);
`endif

        // Contention: IC buffered while DC ids 1..3 are presented
        ic_valid_i = 1'b1;
        ic_addr_i  = 26'h3;
        #1;
        tick;
        ic_valid_i      = 1'b0;
        dc_req_valid_i  = 1'b1;
        dc_req_id_i     = 4'h1;
        dc_req_addr_i   = 40'hAB00;
        mem_req_ready_i = 1'b1;
        #1;
        check("rr_ic_first", mem_req_id_o, 5'h10);
        check("rr_ic_addr", mem_req_addr_o, 40'hC0);
        check("rr_dc_wait", dc_req_ready_o, 1'b0);
        tick;
        check("rr_dc1", mem_req_id_o, 5'h01);
        check("rr_dc1_addr", mem_req_addr_o, 40'hAB00);
        check("rr_dc1_ready", dc_req_ready_o, 1'b1);
        tick;
        dc_req_id_i = 4'h2;
        #1;
        check("rr_dc2", mem_req_id_o, 5'h02);
        check("rr_dc2_ready", dc_req_ready_o, 1'b1);
        tick;
        dc_req_id_i = 4'h3;
        #1;
        check("rr_dc3", mem_req_id_o, 5'h03);
        tick;
        dc_req_valid_i = 1'b0;
        #1;
        check("rr_idle", mem_req_valid_o, 1'b0);
`ifdef MEM_ARB_PERF_CNT_EN
        check("perf_rr_ic", perf_ic_grants_o, 32'd1);
        check("perf_rr_dc", perf_dc_grants_o, 32'd3);
        check("perf_rr_stall", perf_stall_cycles_o, 32'd0);
`endif

        // Overflow while the IC refill is outstanding
        ic_valid_i = 1'b1;
        ic_addr_i  = 26'h7;
        #1;
        tick;
        ic_valid_i = 1'b0;
        #1;
        check("ovf_pulse", ic_overflow_o, 1'b1);
        check("ovf_no_req", mem_req_valid_o, 1'b0);
        check("ovf_busy", ic_busy_o, 1'b1);
        tick;
        check("ovf_one_cycle", ic_overflow_o, 1'b0);
        check("ovf_still_no_req", mem_req_valid_o, 1'b0);

        // IC response, then a repeat with nothing outstanding
        mem_resp_valid_i = 1'b1;
        mem_resp_id_i    = 5'h10;
        mem_resp_last_i  = 1'b1;
        mem_resp_data_i  = line_a5;
        #1;
        check("ic2_valid", ic_valid_o, 1'b1);
        tick;
        check("spur_ic_valid", ic_valid_o, 1'b0);
        check("spur_ic_pulse", spurious_resp_o, 1'b1);
        check("spur_ic_ready", mem_resp_ready_o, 1'b1);
        tick;
        mem_resp_valid_i = 1'b0;
        #1;
        check("final_busy", ic_busy_o, 1'b0);
        check("final_spur", spurious_resp_o, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
